divider: RTL

DIVIDER -- requirements
Module: divider

---
 rtl/divider.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/divider.sv
// Iterative 32-bit integer divider for the pipeline's DIVW/MODW/DIVWU/MODWU ops.
// Radix-2 restoring division on operand magnitudes, one quotient bit per
// cycle, with sign fix-up and divide-by-zero handling applied when the last
// bit is produced. Results are held in DONE while the pipeline is stalled.
module divider (
  input  logic        clk,
  input  logic        rstn,
  input  logic        pipeline_divider_flush,
  input  logic        pipeline_divider_stall,
  input  logic        pipeline_divider_start,
  input  logic [4:0]  pipeline_divider_subtype,
  input  logic [31:0] pipeline_divider_din1,
  input  logic [31:0] pipeline_divider_din2,
  output logic [31:0] divider_pipeline_dout,
  output logic        divider_pipeline_stall,
  output logic        divider_pipeline_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's complement negate.
  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Magnitude of a signed 32-bit value (0x80000000 maps to itself, which is
  // the correct unsigned magnitude).
  function automatic logic [31:0] mag32(input logic [31:0] v);
    return v[31] ? neg32(v) : v;
  endfunction

  state_t      state_r;
  logic [5:0]  cnt_r;
  logic [31:0] quo_r;      // dividend bits shifting out, quotient bits shifting in
  logic [31:0] rem_r;      // partial remainder
  logic [31:0] dsr_r;      // divisor magnitude (or raw divisor for unsigned ops)
  logic        sign1_r;
  logic        sign2_r;
  logic        signed_r;
  logic        rem_sel_r;
  logic        dz_r;
  logic [31:0] dout_r;
  logic        done_r;

  logic        accept_s;
  logic        sub_signed_s;
  logic        sub_rem_s;
  logic [31:0] ld_quo_s;
  logic [31:0] ld_dsr_s;
  logic        ld_sign1_s;
  logic        ld_sign2_s;
  logic [32:0] tmp_s;
  logic [33:0] diff_s;
  logic [31:0] rem_nxt_s;
  logic        qbit_s;
  logic [31:0] quo_nxt_s;
  logic [31:0] q_fix_s;
  logic [31:0] r_fix_s;
  logic [31:0] result_s;

  assign accept_s     = pipeline_divider_start && !pipeline_divider_flush;
  assign sub_signed_s = (pipeline_divider_subtype == 5'd0) || (pipeline_divider_subtype == 5'd1);
  assign sub_rem_s    = (pipeline_divider_subtype == 5'd1) || (pipeline_divider_subtype == 5'd3);

  // Operand values captured when an operation is accepted.
  always_comb begin
    if (sub_signed_s) begin
      ld_quo_s   = mag32(pipeline_divider_din1);
      ld_dsr_s   = mag32(pipeline_divider_din2);
      ld_sign1_s = pipeline_divider_din1[31];
      ld_sign2_s = pipeline_divider_din2[31];
    end else begin
      ld_quo_s   = pipeline_divider_din1;
      ld_dsr_s   = pipeline_divider_din2;
      ld_sign1_s = 1'b0;
      ld_sign2_s = 1'b0;
    end
  end

  // One restoring step: shift in the next dividend bit, trial-subtract the divisor.
  always_comb begin
    tmp_s  = {rem_r, quo_r[31]};
    diff_s = {1'b0, tmp_s} - {2'b00, dsr_r};
    if (diff_s[33]) begin
      rem_nxt_s = tmp_s[31:0];
      qbit_s    = 1'b0;
    end else begin
      rem_nxt_s = diff_s[31:0];
      qbit_s    = 1'b1;
    end
    quo_nxt_s = {quo_r[30:0], qbit_s};
  end

  // Sign fix-up and divide-by-zero override applied to the final step's output.
  // With a zero divisor the remainder naturally ends up as the dividend
  // magnitude, so the dividend sign fix-up restores the original din1.
  always_comb begin
    if (dz_r) begin
      q_fix_s = 32'hFFFF_FFFF;
    end else if (signed_r && (sign1_r ^ sign2_r)) begin
      q_fix_s = neg32(quo_nxt_s);
    end else begin
      q_fix_s = quo_nxt_s;
    end
    if (signed_r && sign1_r) begin
      r_fix_s = neg32(rem_nxt_s);
    end else begin
      r_fix_s = rem_nxt_s;
    end
    if (rem_sel_r) begin
      result_s = r_fix_s;
    end else begin
      result_s = q_fix_s;
    end
  end

  // Stall request: the accepting cycle in IDLE plus every CALC cycle.
  always_comb begin
    if (state_r == CALC) begin
      divider_pipeline_stall = 1'b1;
    end else if (state_r == IDLE) begin
      divider_pipeline_stall = accept_s;
    end else begin
      divider_pipeline_stall = 1'b0;
    end
  end

  // Control FSM, datapath registers and registered result outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r   <= IDLE;
      cnt_r     <= 6'd0;
      quo_r     <= 32'd0;
      rem_r     <= 32'd0;
      dsr_r     <= 32'd0;
      sign1_r   <= 1'b0;
      sign2_r   <= 1'b0;
      signed_r  <= 1'b0;
      rem_sel_r <= 1'b0;
      dz_r      <= 1'b0;
      dout_r    <= 32'd0;
      done_r    <= 1'b0;
    end else if (pipeline_divider_flush) begin
      state_r <= IDLE;
      cnt_r   <= 6'd0;
      dout_r  <= 32'd0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (pipeline_divider_start) begin
            state_r   <= CALC;
            cnt_r     <= 6'd0;
            quo_r     <= ld_quo_s;
            rem_r     <= 32'd0;
            dsr_r     <= ld_dsr_s;
            sign1_r   <= ld_sign1_s;
            sign2_r   <= ld_sign2_s;
            signed_r  <= sub_signed_s;
            rem_sel_r <= sub_rem_s;
            dz_r      <= (pipeline_divider_din2 == 32'd0);
          end else begin
            state_r <= IDLE;
          end
        end
        CALC: begin
          quo_r <= quo_nxt_s;
          rem_r <= rem_nxt_s;
          if (cnt_r == 6'd31) begin
            state_r <= DONE;
            cnt_r   <= 6'd0;
            dout_r  <= result_s;
            done_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r + 6'd1;
          end
        end
        DONE: begin
          if (!pipeline_divider_stall) begin
            dout_r <= 32'd0;
            done_r <= 1'b0;
            if (pipeline_divider_start) begin
              state_r   <= CALC;
              cnt_r     <= 6'd0;
              quo_r     <= ld_quo_s;
              rem_r     <= 32'd0;
              dsr_r     <= ld_dsr_s;
              sign1_r   <= ld_sign1_s;
              sign2_r   <= ld_sign2_s;
              signed_r  <= sub_signed_s;
              rem_sel_r <= sub_rem_s;
              dz_r      <= (pipeline_divider_din2 == 32'd0);
            end else begin
              state_r <= IDLE;
            end
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 6'd0;
          dout_r  <= 32'd0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign divider_pipeline_dout = dout_r;
  assign divider_pipeline_done = done_r;

endmodule
